// File: rtl/commit_stage_pkg.sv
// Shared types for the in-order commit stage: scoreboard head entry,
// retire trace payload and commit FSM states.
package commit_stage_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned RegAddrW = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      ST_WAIT = 2'd1,
      HALTED  = 2'd2
   } commit_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
   } retire_t;

   // is_store / is_ebreak are filled in by the decoder
   typedef struct packed {
      logic                valid;
      logic [XLEN-1:0]     pc;
      logic [XLEN-1:0]     result;
      logic [RegAddrW-1:0] rd;
      logic                rd_we;
      logic                is_store;
      logic                is_ebreak;
   } decoder_t;

endpackage

// File: rtl/commit_stage.sv
// In-order retirement of the scoreboard head: register writeback, store
// drain handshake, retired-instruction counter, retire trace and ebreak halt.
module commit_stage
   import commit_stage_pkg::*;
#(
   parameter int unsigned CntWidth = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  decoder_t            commit_instr,
   output logic                commit_valid,
   output logic                rf_we,
   output logic [RegAddrW-1:0] rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   output logic                st_req_valid,
   input  logic                st_req_ready,
   input  logic                st_ack,
   output logic [CntWidth-1:0] instret,
   output logic                retire_valid,
   output logic [XLEN-1:0]     retire_pc,
   output logic                halt,
   output logic [XLEN-1:0]     halt_code
);

   commit_state_e       state_q, state_d;
   logic [CntWidth-1:0] instret_q;
   retire_t             retire_q;
   logic                halt_q;
   logic [XLEN-1:0]     halt_code_q;
   logic                ebreak_c;

   // Next state and combinational commit controls
   always_comb begin
      state_d      = state_q;
      commit_valid = 1'b0;
      rf_we        = 1'b0;
      rf_waddr     = '0;
      rf_wdata     = '0;
      st_req_valid = 1'b0;
      ebreak_c     = 1'b0;

      unique case (state_q)
         RUN: begin
            if (commit_instr.valid) begin
               if (commit_instr.is_store) begin
                  st_req_valid = 1'b1;
                  if (st_req_ready) state_d = ST_WAIT;
               end else if (commit_instr.is_ebreak) begin
                  commit_valid = 1'b1;
                  ebreak_c     = 1'b1;
                  state_d      = HALTED;
               end else begin
                  commit_valid = 1'b1;
                  rf_we        = commit_instr.rd_we && (commit_instr.rd != '0);
               end
            end
         end
         ST_WAIT: begin
            // the store stays at the head until the buffer reports it done
            if (st_ack) begin
               commit_valid = commit_instr.valid;
               state_d      = RUN;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (rf_we) begin
         rf_waddr = commit_instr.rd;
         rf_wdata = commit_instr.result;
      end
   end

   // State, counter, retire trace and halt registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         instret_q   <= '0;
         retire_q    <= '0;
         halt_q      <= 1'b0;
         halt_code_q <= '0;
      end else begin
         state_q        <= state_d;
         retire_q.valid <= commit_valid;
         if (commit_valid) begin
            instret_q   <= instret_q + CntWidth'(1);
            retire_q.pc <= commit_instr.pc;
         end
         if (ebreak_c) begin
            halt_q      <= 1'b1;
            halt_code_q <= commit_instr.result;
         end
      end
   end

   assign instret      = instret_q;
   assign retire_valid = retire_q.valid;
   assign retire_pc    = retire_q.pc;
   assign halt         = halt_q;
   assign halt_code    = halt_code_q;

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios plus randomized
// ALU retirement against a counting reference model.
module tb_commit_stage;
   import commit_stage_pkg::*;

   logic                clock = 1'b0;
   logic                reset;
   decoder_t            instr;
   logic                st_req_ready, st_ack;
   logic                commit_valid, rf_we, st_req_valid;
   logic [RegAddrW-1:0] rf_waddr;
   logic [XLEN-1:0]     rf_wdata;
   logic [63:0]         instret;
   logic                retire_valid, halt;
   logic [XLEN-1:0]     retire_pc, halt_code;

   // narrow-counter instance sharing all inputs, used to observe wrap-around
   logic                w_commit_valid, w_rf_we, w_st_req_valid;
   logic [RegAddrW-1:0] w_rf_waddr;
   logic [XLEN-1:0]     w_rf_wdata;
   logic [2:0]          w_instret;
   logic                w_retire_valid, w_halt;
   logic [XLEN-1:0]     w_retire_pc, w_halt_code;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_cnt = '0;
   logic [63:0] exp_pc  = '0;

   commit_stage #(.CntWidth(64)) dut (
      .clock(clock), .reset(reset), .commit_instr(instr),
      .commit_valid(commit_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_ack(st_ack),
      .instret(instret), .retire_valid(retire_valid), .retire_pc(retire_pc),
      .halt(halt), .halt_code(halt_code));

   commit_stage #(.CntWidth(3)) dut_w (
      .clock(clock), .reset(reset), .commit_instr(instr),
      .commit_valid(w_commit_valid), .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
      .st_req_valid(w_st_req_valid), .st_req_ready(st_req_ready), .st_ack(st_ack),
      .instret(w_instret), .retire_valid(w_retire_valid), .retire_pc(w_retire_pc),
      .halt(w_halt), .halt_code(w_halt_code));

   always #5 clock = ~clock;

   function automatic decoder_t mk(input logic v, input logic [63:0] pc, input logic [63:0] res,
                                   input logic [4:0] rd, input logic we, input logic st, input logic eb);
      decoder_t d;
      d.valid = v; d.pc = pc; d.result = res; d.rd = rd;
      d.rd_we = we; d.is_store = st; d.is_ebreak = eb;
      return d;
   endfunction

   task automatic test_reset();
      reset = 1'b0; instr = '0; st_req_ready = 1'b0; st_ack = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got=%0h exp=0", instret); end
      checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_valid got=%0b exp=0", retire_valid); end
      checks++; if (retire_pc !== 64'd0) begin errors++; $display("FAIL reset_retire_pc got=%0h exp=0", retire_pc); end
      checks++; if (halt !== 1'b0 || halt_code !== 64'd0) begin errors++; $display("FAIL reset_halt got=%0b/%0h exp=0/0", halt, halt_code); end
      checks++; if ({commit_valid, rf_we, st_req_valid} !== 3'b000 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0)
         begin errors++; $display("FAIL reset_comb got=%b exp=000", {commit_valid, rf_we, st_req_valid}); end
      @(negedge clock); reset = 1'b1;
      exp_cnt = '0; exp_pc = '0;
   endtask

   task automatic test_alu_seq();
      for (int i = 0; i < 3; i++) begin
         logic [63:0] pc, res;
         pc  = 64'h1000 + 64'(4 * i);
         res = 64'h11 * 64'(i + 1);
         @(negedge clock);
         instr = mk(1'b1, pc, res, 5'(i + 1), 1'b1, 1'b0, 1'b0);
         #1;
         checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL alu_commit[%0d] got=%0b exp=1", i, commit_valid); end
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== res)
            begin errors++; $display("FAIL alu_rf[%0d] got=%0b/%0d/%0h exp=1/%0d/%0h", i, rf_we, rf_waddr, rf_wdata, i + 1, res); end
         @(posedge clock); exp_cnt++; exp_pc = pc; #1;
         checks++; if (retire_valid !== 1'b1 || retire_pc !== exp_pc)
            begin errors++; $display("FAIL alu_retire[%0d] got=%0b/%0h exp=1/%0h", i, retire_valid, retire_pc, exp_pc); end
      end
      checks++; if (instret !== 64'd3) begin errors++; $display("FAIL alu_instret got=%0d exp=3", instret); end
   endtask

   task automatic test_rd_zero();
      @(negedge clock);
      instr = mk(1'b1, 64'h2000, 64'hdead, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (commit_valid !== 1'b1 || rf_we !== 1'b0)
         begin errors++; $display("FAIL rd_zero got=%0b/%0b exp=1/0", commit_valid, rf_we); end
      @(posedge clock); exp_cnt++; exp_pc = 64'h2000; #1;
      checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL rd_zero_instret got=%0d exp=%0d", instret, exp_cnt); end
   endtask

   // store at head: request held until accepted, commit only in the ack cycle
   task automatic test_store(input int ready_delay, input int ack_delay);
      logic [63:0] pc;
      pc = 64'h3000 + 64'(ready_delay * 16 + ack_delay);
      for (int c = 0; c <= ready_delay; c++) begin
         @(negedge clock);
         instr = mk(1'b1, pc, 64'h5555, 5'd7, 1'b1, 1'b1, 1'b0);
         st_req_ready = (c == ready_delay);
         st_ack = 1'b1;
         #1;
         checks++; if (st_req_valid !== 1'b1 || commit_valid !== 1'b0 || rf_we !== 1'b0)
            begin errors++; $display("FAIL store_req[%0d] got=%0b/%0b/%0b exp=1/0/0", c, st_req_valid, commit_valid, rf_we); end
      end
      for (int k = 1; k <= ack_delay; k++) begin
         @(negedge clock);
         st_req_ready = 1'b1;
         st_ack = (k == ack_delay);
         #1;
         checks++; if (st_req_valid !== 1'b0 || rf_we !== 1'b0 || commit_valid !== (k == ack_delay))
            begin errors++; $display("FAIL store_wait[%0d] got=%0b/%0b/%0b exp=0/0/%0b", k, st_req_valid, rf_we, commit_valid, k == ack_delay); end
      end
      @(posedge clock); exp_cnt++; exp_pc = pc; #1;
      checks++; if (instret !== exp_cnt || retire_valid !== 1'b1 || retire_pc !== exp_pc)
         begin errors++; $display("FAIL store_retire got=%0d/%0b/%0h exp=%0d/1/%0h", instret, retire_valid, retire_pc, exp_cnt, exp_pc); end
      @(negedge clock); st_ack = 1'b0; st_req_ready = 1'b0; instr = '0;
      @(posedge clock); #1;
      checks++; if (retire_valid !== 1'b0 || retire_pc !== exp_pc)
         begin errors++; $display("FAIL store_idle got=%0b/%0h exp=0/%0h", retire_valid, retire_pc, exp_pc); end
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         logic v, we, exp_we;
         logic [4:0] rd;
         logic [63:0] pc, res;
         v = ($urandom_range(0, 3) != 0);
         rd = 5'($urandom_range(0, 31));
         we = 1'($urandom);
         pc = {32'h0, $urandom} & ~64'h3;
         res = {$urandom, $urandom};
         @(negedge clock);
         instr = mk(v, pc, res, rd, we, 1'b0, 1'b0);
         st_ack = 1'($urandom);
         st_req_ready = 1'($urandom);
         exp_we = v && we && (rd != 5'd0);
         #1;
         checks++; if (commit_valid !== v || rf_we !== exp_we || st_req_valid !== 1'b0)
            begin errors++; $display("FAIL rand_ctl[%0d] got=%0b/%0b/%0b exp=%0b/%0b/0", i, commit_valid, rf_we, st_req_valid, v, exp_we); end
         if (exp_we) begin
            checks++; if (rf_waddr !== rd || rf_wdata !== res)
               begin errors++; $display("FAIL rand_rf[%0d] got=%0d/%0h exp=%0d/%0h", i, rf_waddr, rf_wdata, rd, res); end
         end
         @(posedge clock);
         if (v) begin exp_cnt++; exp_pc = pc; end
         #1;
         checks++; if (instret !== exp_cnt || w_instret !== 3'(exp_cnt) || retire_valid !== v || retire_pc !== exp_pc)
            begin errors++; $display("FAIL rand_state[%0d] got=%0d/%0d/%0b/%0h exp=%0d/%0d/%0b/%0h", i, instret, w_instret, retire_valid, retire_pc, exp_cnt, 3'(exp_cnt), v, exp_pc); end
      end
      @(negedge clock); instr = '0; st_ack = 1'b0; st_req_ready = 1'b0;
   endtask

   task automatic test_reset_mid_store();
      @(negedge clock);
      instr = mk(1'b1, 64'h4000, 64'h0, 5'd1, 1'b0, 1'b1, 1'b0);
      st_req_ready = 1'b1;
      @(negedge clock);
      st_req_ready = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if (instret !== 64'd0 || retire_pc !== 64'd0)
         begin errors++; $display("FAIL midrst_clear got=%0d/%0h exp=0/0", instret, retire_pc); end
      @(negedge clock); reset = 1'b1; exp_cnt = '0; exp_pc = '0;
      instr = mk(1'b1, 64'h4100, 64'h77, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (commit_valid !== 1'b1 || rf_we !== 1'b1)
         begin errors++; $display("FAIL midrst_alu got=%0b/%0b exp=1/1", commit_valid, rf_we); end
      @(posedge clock); exp_cnt++; exp_pc = 64'h4100;
      @(negedge clock);
      instr = mk(1'b1, 64'h4200, 64'h0, 5'd1, 1'b0, 1'b1, 1'b0);
      st_ack = 1'b1;
      #1;
      checks++; if (commit_valid !== 1'b0 || st_req_valid !== 1'b1)
         begin errors++; $display("FAIL midrst_late_ack got=%0b/%0b exp=0/1", commit_valid, st_req_valid); end
      @(posedge clock); #1;
      checks++; if (instret !== 64'd1) begin errors++; $display("FAIL midrst_instret got=%0d exp=1", instret); end
      @(negedge clock); instr = '0; st_ack = 1'b0;
   endtask

   task automatic test_wrap();
      reset = 1'b0;
      @(negedge clock); reset = 1'b1; exp_cnt = '0; exp_pc = '0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         instr = mk(1'b1, 64'h5000 + 64'(i * 4), 64'(i), 5'd3, 1'b1, 1'b0, 1'b0);
         @(posedge clock); exp_cnt++; exp_pc = 64'h5000 + 64'(i * 4); #1;
         if (i >= 6) begin
            checks++; if (w_instret !== 3'(exp_cnt))
               begin errors++; $display("FAIL wrap[%0d] got=%0d exp=%0d", i, w_instret, 3'(exp_cnt)); end
         end
      end
      checks++; if (instret !== 64'd9) begin errors++; $display("FAIL wrap_wide got=%0d exp=9", instret); end
   endtask

   task automatic test_ebreak();
      logic [63:0] frozen;
      @(negedge clock);
      instr = mk(1'b1, 64'h6000, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++; if (commit_valid !== 1'b1 || rf_we !== 1'b0)
         begin errors++; $display("FAIL ebreak_commit got=%0b/%0b exp=1/0", commit_valid, rf_we); end
      @(posedge clock); exp_cnt++; exp_pc = 64'h6000; #1;
      checks++; if (halt !== 1'b1 || halt_code !== 64'd0 || retire_pc !== exp_pc || instret !== exp_cnt)
         begin errors++; $display("FAIL ebreak_halt got=%0b/%0h/%0h/%0d exp=1/0/%0h/%0d", halt, halt_code, retire_pc, instret, exp_pc, exp_cnt); end
      frozen = exp_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         instr = mk(1'b1, 64'h6100, 64'hab, 5'd4, 1'b1, (i == 3), 1'b0);
         st_req_ready = 1'b1; st_ack = 1'b1;
         #1;
         checks++; if (commit_valid !== 1'b0 || rf_we !== 1'b0 || st_req_valid !== 1'b0)
            begin errors++; $display("FAIL halted_comb[%0d] got=%b exp=000", i, {commit_valid, rf_we, st_req_valid}); end
         @(posedge clock); #1;
         checks++; if (instret !== frozen || halt !== 1'b1 || retire_valid !== 1'b0)
            begin errors++; $display("FAIL halted_state[%0d] got=%0d/%0b/%0b exp=%0d/1/0", i, instret, halt, retire_valid, frozen); end
      end
   endtask

   initial begin
      test_reset();
      test_alu_seq();
      test_rd_zero();
      test_store(2, 3);
      test_store(0, 1);
      test_random(150);
      test_store($urandom_range(0, 4), $urandom_range(1, 4));
      test_reset_mid_store();
      test_wrap();
      test_ebreak();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/commit_stage.md
# commit_stage

In-order retirement unit at the read end of the issue-stage scoreboard. Each cycle it inspects the scoreboard head entry, `commit_instr`. Once that entry's result has been written back, it retires the entry:
- writes the result to the architectural register file,
- releases stores to the store buffer through a request/acknowledge handshake,
- pulses `commit_valid` so the scoreboard frees the entry.

It also keeps the retired-instruction counter, produces a registered retire trace for difftest, and stops the machine on `ebreak`.

## Interface
Parameters:
- `CntWidth`, 64: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `commit_instr`  in  decoder_t  scoreboard head entry. Fields consumed: `valid`, `result`, `rd`, `rd_we`, `is_store`, `is_ebreak`, `pc`.
- `commit_valid`  out  1  retire the head entry; the scoreboard advances its commit pointer on the next edge.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  destination register.
- `rf_wdata`  out  XLEN  write data (`commit_instr.result`).
- `st_req_valid`  out  1  request to drain the oldest buffered store.
- `st_req_ready`  in  1  store buffer accepts the request.
- `st_ack`  in  1  store performed; one-cycle pulse, arrives no earlier than the cycle after acceptance.
- `instret`  out  CntWidth  retired-instruction count.
- `retire_valid`  out  1  registered: one instruction retired last cycle.
- `retire_pc`  out  XLEN  registered PC of that instruction.
- `halt`  out  1  registered: `ebreak` retired; sticky.
- `halt_code`  out  XLEN  registered `commit_instr.result` of the `ebreak`; the EXU places a0 there.

## Operation
- FSM states: `RUN`, `ST_WAIT`, `HALTED`.
- Definition: `head_ok` = `commit_instr.valid` and state == `RUN`.
- Non-store, non-`ebreak` instruction:
  - `commit_valid` = `head_ok`.
  - `rf_we` = `head_ok` and `rd_we` and `rd != 0`.
  - State stays `RUN`.
- Store:
  - In `RUN`, `st_req_valid` = `head_ok`; `commit_valid` stays 0.
  - When `st_req_valid` and `st_req_ready`, go to `ST_WAIT`; `st_req_valid` drops the next cycle.
  - In `ST_WAIT`, on `st_ack`: `commit_valid` = 1 that cycle and go to `RUN`. `rf_we` is never asserted for a store.
- `ebreak`: `commit_valid` = `head_ok`, then go to `HALTED`. On the same edge, `halt` <= 1 and `halt_code` <= `result`.
- `HALTED` is absorbing: no `commit_valid`, `rf_we` or `st_req_valid` until reset.
- `st_ack` outside `ST_WAIT` is ignored.
- `instret` increments by 1 on every edge where `commit_valid` = 1. It wraps modulo 2^CntWidth.
- Retire trace: on every edge, `retire_valid` <= `commit_valid`; `retire_pc` <= `commit_instr.pc` when `commit_valid`, otherwise held.

## Timing
- Combinational outputs: `commit_valid`, `rf_*` and `st_req_valid` depend on `commit_instr` and the current state in the same cycle.
- Latency from writeback to retire:
  - non-store: 1 cycle (scoreboard registers `valid`, then commit in the next cycle);
  - store: 1 cycle plus the store-buffer ack latency.
- Throughput: 1 retire per cycle for back-to-back ready non-stores.
- `retire_*`, `halt` and `halt_code` appear 1 cycle after the corresponding `commit_valid`.
- `st_req_valid` must stay asserted while unaccepted; it may not drop before `st_req_ready`.
- Reset values: state `RUN`, `instret` 0, `retire_valid` 0, `retire_pc` 0, `halt` 0, `halt_code` 0.
- Reset mid-`ST_WAIT` returns to `RUN`; any pending ack is discarded.
- Head not valid means all combinational outputs are 0.

## Structure
- Shared package gets:
  - `commit_state_e` {`RUN`, `ST_WAIT`, `HALTED`};
  - a `retire_t` struct {`valid`, `pc`} for difftest;
  - `XLEN`.
- `decoder_t` stays in the package; the `is_store` and `is_ebreak` flags are populated by the decoder.
- Single module; no sub-module is warranted.

## Test plan
- Three ALU ops with `rd` = 1/2/3 and results 0x11/0x22/0x33, valid in consecutive cycles -> three consecutive `commit_valid` pulses, matching `rf_*` writes, `instret` = 3, `retire_pc` sequence matches.
- Ready head with `rd` = 0, `rd_we` = 1 -> `commit_valid` = 1, `rf_we` = 0.
- Store at head with `st_req_ready` held 0 for 2 cycles, then `st_ack` 3 cycles after acceptance -> `st_req_valid` held 3 cycles, then 0; `commit_valid` only in the ack cycle; `instret` +1.
- `ebreak` with result 0 -> `halt` = 1 and `halt_code` = 0 the next cycle. A following ready ALU op is never committed; `instret` frozen.
- Assert `reset` during `ST_WAIT`, release, present a ready ALU op -> commits next cycle; `instret` = 1; late `st_ack` ignored.
- Preload `instret` near 2^64-1 (force) and retire 2 instructions -> `instret` wraps to 0 and then 1.
